// File: rtl/conv_pkg.sv
// Shared types for the convolution accumulator layer: FSM states and accumulator width.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_POST = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Wide enough that ICH windows of K*K products can never overflow.
  function automatic int unsigned acc_w(input int unsigned b, input int unsigned k,
                                        input int unsigned ich);
    return 2 * b + 1 + $clog2(k * k) + $clog2(ich);
  endfunction

endpackage

// File: rtl/conv_acc_lane.sv
// One output channel: K*K multiply-add per window, accumulation, bias/shift/saturate.
// Build option CONV_ACC_RELU_EN selects ReLU with unsigned saturation.
module conv_acc_lane
  import conv_pkg::*;
#(
  parameter int unsigned B     = 8,
  parameter int unsigned K     = 3,
  parameter int unsigned ICH   = 16,
  parameter int unsigned SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_en,
  input  logic             post_en,
  input  logic [K*K*B-1:0] win,
  input  logic [K*K*B-1:0] weight,
  input  logic [B-1:0]     bias,
  output logic [B-1:0]     data
);

  localparam int unsigned KK    = K * K;
  localparam int unsigned PW    = 2 * B + 1;
  localparam int unsigned ACC_W = acc_w(B, K, ICH);

  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((2 ** (B - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = -SMAX - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] UMAX = ACC_W'((2 ** B) - 1);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] win_sum;
  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] shifted;
  logic        [B-1:0]     res;

  // Dot product of one window against this lane's weights for the current channel.
  always_comb begin
    logic signed [PW-1:0] px;
    logic signed [PW-1:0] wt;
    win_sum = '0;
    for (int k = 0; k < int'(KK); k++) begin
      px      = PW'(win[k*B +: B]);
      wt      = PW'(signed'(weight[k*B +: B]));
      win_sum = win_sum + ACC_W'(px * wt);
    end
  end

  always_comb begin
    biased  = acc + ACC_W'(signed'(bias));
    shifted = biased >>> SHIFT;
    res     = '0;
`ifdef CONV_ACC_RELU_EN
    if (shifted < 0)         res = '0;
    else if (shifted > UMAX) res = '1;
    else                     res = B'(shifted);
`else
    if (shifted > SMAX)      res = B'(SMAX);
    else if (shifted < SMIN) res = B'(SMIN);
    else                     res = B'(shifted);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      data <= '0;
    end else if (post_en) begin
      acc  <= '0;
      data <= res;
    end else if (acc_en) begin
      acc  <= acc + win_sum;
    end
  end

endmodule

// File: rtl/conv_acc_layer.sv
// Convolution accumulator layer: OCH parallel lanes accumulate ICH windows, then emit one result.
// Build option CONV_ACC_RELU_EN enables ReLU output (passed through to each lane).
module conv_acc_layer
  import conv_pkg::*;
#(
  parameter int unsigned B     = 8,
  parameter int unsigned K     = 3,
  parameter int unsigned ICH   = 16,
  parameter int unsigned OCH   = 32,
  parameter int unsigned SHIFT = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [K*K*B-1:0]           i_win_data,
  input  logic                       i_win_valid,
  output logic                       o_win_ready,
  output logic [$clog2(ICH)-1:0]     o_ich_idx,
  input  logic [OCH*ICH*K*K*B-1:0]   i_weight,
  input  logic [OCH*B-1:0]           i_bias,
  output logic [OCH*B-1:0]           o_data,
  output logic                       o_data_valid,
  input  logic                       i_data_ready
);

  localparam int unsigned KK = K * K;
  localparam int unsigned IW = $clog2(ICH);

  state_t state;
  state_t state_n;
  logic   accept;
  logic   last;
  logic   acc_en;
  logic   post_en;

  assign accept = i_win_valid & o_win_ready;
  assign last   = (o_ich_idx == IW'(ICH - 1));

  always_comb begin
    state_n = state;
    acc_en  = 1'b0;
    post_en = 1'b0;
    case (state)
      ST_ACC: begin
        if (accept) begin
          acc_en = 1'b1;
          if (last) state_n = ST_POST;
        end
      end
      ST_POST: begin
        post_en = 1'b1;
        state_n = ST_OUT;
      end
      ST_OUT: begin
        if (i_data_ready) state_n = ST_ACC;
      end
      default: state_n = ST_ACC;
    endcase
  end

  // Handshake flags are registered from the next state so they track the FSM exactly.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state        <= ST_ACC;
      o_win_ready  <= 1'b1;
      o_data_valid <= 1'b0;
      o_ich_idx    <= '0;
    end else begin
      state        <= state_n;
      o_win_ready  <= (state_n == ST_ACC);
      o_data_valid <= (state_n == ST_OUT);
      if (acc_en) o_ich_idx <= last ? '0 : o_ich_idx + IW'(1);
    end
  end

  for (genvar c = 0; c < int'(OCH); c++) begin : g_lane
    logic [KK*B-1:0] lane_w;

    assign lane_w = i_weight[(c * ICH + 32'(o_ich_idx)) * KK * B +: KK * B];

    conv_acc_lane #(
      .B     (B),
      .K     (K),
      .ICH   (ICH),
      .SHIFT (SHIFT)
    ) u_lane (
      .clk     (i_clk),
      .rst_n   (i_rst),
      .acc_en  (acc_en),
      .post_en (post_en),
      .win     (i_win_data),
      .weight  (lane_w),
      .bias    (i_bias[c*B +: B]),
      .data    (o_data[c*B +: B])
    );
  end

endmodule

// File: tb/tb_conv_acc_layer.sv
// Scoreboard bench for conv_acc_layer: random frames checked against a plain-arithmetic model.
module tb_conv_acc_layer;

  localparam int B     = 8;
  localparam int K     = 3;
  localparam int ICH   = 16;
  localparam int OCH   = 32;
  localparam int SHIFT = 4;
  localparam int KK    = K * K;
  localparam int IW    = $clog2(ICH);
  localparam int OUT_W = OCH * B;

  logic                     i_clk = 1'b0;
  logic                     i_rst;
  logic [KK*B-1:0]          i_win_data;
  logic                     i_win_valid;
  logic                     o_win_ready;
  logic [IW-1:0]            o_ich_idx;
  logic [OCH*ICH*KK*B-1:0]  i_weight;
  logic [OCH*B-1:0]         i_bias;
  logic [OUT_W-1:0]         o_data;
  logic                     o_data_valid;
  logic                     i_data_ready;

  conv_acc_layer #(.B(B), .K(K), .ICH(ICH), .OCH(OCH), .SHIFT(SHIFT)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_win_data   (i_win_data),
    .i_win_valid  (i_win_valid),
    .o_win_ready  (o_win_ready),
    .o_ich_idx    (o_ich_idx),
    .i_weight     (i_weight),
    .i_bias       (i_bias),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_data_ready (i_data_ready)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;
  logic [OUT_W-1:0] exp_q[$];

  int pix[ICH][KK];
  int wt[OCH][ICH][KK];
  int bs[OCH];

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout", name);
  endtask

  // Reference: convolve, add bias, floor-shift, clamp.
  function automatic logic [OUT_W-1:0] model();
    logic [OUT_W-1:0] r;
    int s;
    r = '0;
    for (int c = 0; c < OCH; c++) begin
      s = 0;
      for (int i = 0; i < ICH; i++)
        for (int k = 0; k < KK; k++)
          s += pix[i][k] * wt[c][i][k];
      s = (s + bs[c]) >>> SHIFT;
`ifdef CONV_ACC_RELU_EN
      if (s < 0) s = 0;
      if (s > 255) s = 255;
`else
      if (s > 127) s = 127;
      if (s < -128) s = -128;
`endif
      r[c*B +: B] = B'(s);
    end
    return r;
  endfunction

  function automatic int rnd(input int lo, input int hi);
    return int'($urandom_range(32'(hi - lo))) + lo;
  endfunction

  task automatic fill(input int plo, input int phi, input int wlo, input int whi,
                      input int blo, input int bhi);
    for (int i = 0; i < ICH; i++)
      for (int k = 0; k < KK; k++) pix[i][k] = rnd(plo, phi);
    for (int c = 0; c < OCH; c++) begin
      bs[c] = rnd(blo, bhi);
      for (int i = 0; i < ICH; i++)
        for (int k = 0; k < KK; k++) wt[c][i][k] = rnd(wlo, whi);
    end
  endtask

  task automatic apply_cfg();
    for (int c = 0; c < OCH; c++) begin
      i_bias[c*B +: B] = B'(bs[c]);
      for (int i = 0; i < ICH; i++)
        for (int k = 0; k < KK; k++)
          i_weight[((c*ICH + i)*KK + k)*B +: B] = B'(wt[c][i][k]);
    end
  endtask

  function automatic logic [KK*B-1:0] win_vec(input int i);
    logic [KK*B-1:0] v;
    for (int k = 0; k < KK; k++) v[k*B +: B] = B'(pix[i][k]);
    return v;
  endfunction

  task automatic send_win(input int i, input int gap);
    bit acc;
    int n;
    i_win_valid = 1'b0;
    repeat (gap) begin @(posedge i_clk); #1; end
    i_win_data  = win_vec(i);
    i_win_valid = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 500) begin
      @(negedge i_clk);
      acc = o_win_ready;
      if (acc) chk("ich_idx", OUT_W'(o_ich_idx), OUT_W'(i));
      @(posedge i_clk); #1;
      n++;
    end
    i_win_valid = 1'b0;
    if (!acc) fail_now("win_accept");
  endtask

  task automatic send_frame(input int maxgap, input bit lat);
    apply_cfg();
    exp_q.push_back(model());
    for (int i = 0; i < ICH; i++) send_win(i, rnd(0, maxgap));
    if (lat) begin
      @(negedge i_clk);
      chk("valid_post", OUT_W'(o_data_valid), OUT_W'(0));
      @(negedge i_clk);
      chk("valid_out", OUT_W'(o_data_valid), OUT_W'(1));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge i_clk); n++; end
    #1;
    if (exp_q.size() != 0) fail_now("drain");
  endtask

  // Monitor: every consumed result is checked against the oldest expected one.
  always @(negedge i_clk) begin
    if (i_rst && o_data_valid && i_data_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h want none", o_data);
      end else begin
        chk("sb_data", o_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    i_rst        = 1'b0;
    i_win_valid  = 1'b0;
    i_win_data   = '0;
    i_weight     = '0;
    i_bias       = '0;
    i_data_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("rst_win_ready", OUT_W'(o_win_ready), OUT_W'(1));
    chk("rst_valid", OUT_W'(o_data_valid), OUT_W'(0));
    chk("rst_data", o_data, '0);
    chk("rst_ich", OUT_W'(o_ich_idx), OUT_W'(0));
    @(posedge i_clk); #1;

    // Ones with bias 16: every byte is (144+16)>>4 = 10.
    fill(1, 1, 1, 1, 16, 16);
    send_frame(0, 1);
    drain();

    // Negative sum and positive saturation.
    fill(1, 1, -1, -1, 0, 0);
    send_frame(0, 1);
    drain();
    fill(255, 255, 127, 127, 0, 0);
    send_frame(0, 0);
    drain();

    // Downstream stall while a window is offered.
    fill(1, 1, 1, 1, 16, 16);
    i_data_ready = 1'b0;
    send_frame(0, 0);
    begin
      int n;
      n = 0;
      @(negedge i_clk);
      while (!o_data_valid && n < 20) begin @(negedge i_clk); n++; end
      if (!o_data_valid) fail_now("stall_valid");
    end
    i_win_data  = win_vec(0);
    i_win_valid = 1'b1;
    repeat (5) begin
      @(negedge i_clk);
      chk("stall_data", o_data, exp_q[0]);
      chk("stall_valid", OUT_W'(o_data_valid), OUT_W'(1));
      chk("stall_win_ready", OUT_W'(o_win_ready), OUT_W'(0));
      chk("stall_ich", OUT_W'(o_ich_idx), OUT_W'(0));
    end
    @(posedge i_clk); #1;
    i_data_ready = 1'b1;
    @(posedge i_clk); #1;
    i_win_valid = 1'b0;
    @(negedge i_clk);
    chk("resume_win_ready", OUT_W'(o_win_ready), OUT_W'(1));
    chk("resume_ich", OUT_W'(o_ich_idx), OUT_W'(0));
    chk("resume_empty", OUT_W'(exp_q.size()), OUT_W'(0));
    @(posedge i_clk); #1;

    // Reset mid-frame discards the partial accumulation.
    fill(3, 9, -5, 5, -20, 20);
    apply_cfg();
    for (int i = 0; i < 7; i++) send_win(i, 0);
    #2;
    i_rst = 1'b0;
    #1;
    chk("mid_rst_ich", OUT_W'(o_ich_idx), OUT_W'(0));
    chk("mid_rst_data", o_data, '0);
    chk("mid_rst_valid", OUT_W'(o_data_valid), OUT_W'(0));
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    fill(1, 1, 1, 1, 16, 16);
    send_frame(0, 1);
    drain();

    // Same random frame gap-free and with valid gaps.
    fill(0, 15, -8, 7, -64, 63);
    send_frame(0, 0);
    drain();
    send_frame(3, 0);
    drain();
    for (int f = 0; f < 2; f++) begin
      fill(0, 15, -8, 7, -128, 127);
      send_frame(3, 1);
      drain();
    end
    fill(0, 255, -128, 127, -128, 127);
    send_frame(2, 0);
    drain();

    chk("final_empty", OUT_W'(exp_q.size()), OUT_W'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
